// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: fetch FSM encoding,
// index-width helper and the byte-address legality check.
package memory_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HIT  = 2'd2;

    // Bits needed to index 'depth' entries (at least one).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Word aligned and inside the array; compared at 34 bits so
    // 4*depth cannot wrap.
    function automatic logic addr_legal(
        input logic [31:0] addr,
        input int unsigned depth
    );
        logic [33:0] limit;
        limit = 34'(depth) << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// CPU <-> memory bus: instruction-fetch port, data port, error flag.
// master = CPU side, slave = memory responder side.
interface memory_responder_if;

    logic [31:0] inst_addr;
    logic        inst_success;
    logic [31:0] inst_data;
    logic        data_read_en;
    logic        data_write_en;
    logic [31:0] data_addr;
    logic [31:0] data_write_data;
    logic [31:0] data_read_data;
    logic        range_error;

    modport master (
        output inst_addr,
        output data_read_en,
        output data_write_en,
        output data_addr,
        output data_write_data,
        input  inst_success,
        input  inst_data,
        input  data_read_data,
        input  range_error
    );

    modport slave (
        input  inst_addr,
        input  data_read_en,
        input  data_write_en,
        input  data_addr,
        input  data_write_data,
        output inst_success,
        output inst_data,
        output data_read_data,
        output range_error
    );

endinterface

// File: rtl/memory_responder_word_ram.sv
// DEPTH_WORDS x 32 word array: one combinational read port, one write
// port at the rising edge. Ports: clk, rd_idx/rd_data, wr_en/wr_idx/wr_data.
module memory_responder_word_ram
    import memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = idx_width(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [DEPTH_WORDS];

    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory responder: single-cycle data port with priority over a
// multi-cycle instruction fetch sharing one array read port.
// Ports: clk, reset (sync, active-high), bus (memory_responder_if.slave).
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter int unsigned FETCH_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    memory_responder_if.slave  bus
);

    localparam int unsigned AW = idx_width(DEPTH_WORDS);
    localparam int unsigned CW = idx_width(FETCH_LATENCY);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(FETCH_LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   inst_data_q, inst_data_d;
    logic          range_error_q, range_error_d;

    logic          data_access;
    logic          data_legal;
    logic          fetch_legal;
    logic          addr_change;
    logic          fetch_word_wr;
    logic          ram_we;
    logic [AW-1:0] ram_rd_idx;
    logic [31:0]   ram_rd_data;

    assign data_access = bus.data_read_en | bus.data_write_en;
    assign data_legal  = addr_legal(bus.data_addr, DEPTH_WORDS);
    assign fetch_legal = addr_legal(fetch_addr_q, DEPTH_WORDS);
    assign addr_change = bus.inst_addr != fetch_addr_q;

    // A legal store that lands on the word being fetched or held.
    assign fetch_word_wr = bus.data_write_en && data_legal &&
                           (bus.data_addr[31:2] == fetch_addr_q[31:2]);

    assign ram_we = bus.data_write_en & data_legal & ~reset;

    // The data port owns the read port whenever it is active.
    assign ram_rd_idx = data_access ? bus.data_addr[AW+1:2]
                                    : fetch_addr_q[AW+1:2];

    memory_responder_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .rd_idx  (ram_rd_idx),
        .rd_data (ram_rd_data),
        .wr_en   (ram_we),
        .wr_idx  (bus.data_addr[AW+1:2]),
        .wr_data (bus.data_write_data)
    );

    assign bus.data_read_data = (bus.data_read_en && data_legal)
                                ? ram_rd_data : 32'h0;
    assign bus.inst_success   = (state_q == ST_HIT) && !addr_change;
    assign bus.inst_data      = inst_data_q;
    assign bus.range_error    = range_error_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fetch_addr_d  = fetch_addr_q;
        inst_data_d   = inst_data_q;
        range_error_d = range_error_q | (data_access & ~data_legal);

        unique case (state_q)
            ST_IDLE: begin
                fetch_addr_d = bus.inst_addr;
                cnt_d        = CNT_RELOAD;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (addr_change) begin
                    fetch_addr_d = bus.inst_addr;
                    cnt_d        = CNT_RELOAD;
                end else if (data_access) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    // Read port is free here, so ram_rd_data is fetch_addr's word.
                    inst_data_d = fetch_legal ? ram_rd_data : 32'h0;
                    if (!fetch_legal) begin
                        range_error_d = 1'b1;
                    end
                    state_d = ST_HIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HIT: begin
                if (addr_change) begin
                    fetch_addr_d = bus.inst_addr;
                    cnt_d        = CNT_RELOAD;
                    state_d      = ST_WAIT;
                end else if (fetch_word_wr) begin
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            fetch_addr_q  <= 32'h0;
            inst_data_q   <= 32'h0;
            range_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fetch_addr_q  <= fetch_addr_d;
            inst_data_q   <= inst_data_d;
            range_error_q <= range_error_d;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: word model plus a queue of
// expected read/fetch results popped when the DUT presents them.
module tb_memory_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    memory_responder_if bus ();

    memory_responder #(
        .DEPTH_WORDS   (DEPTH),
        .FETCH_LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [int];
    logic [31:0] exp_q [$];
    bit          saw_mem1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        if (!legal(a)) return 32'h0;
        return model.exists(k) ? model[k] : 32'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.data_read_en    = 1'b0;
        bus.data_write_en   = 1'b0;
        bus.data_addr       = 32'h0;
        bus.data_write_data = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.data_write_en   = 1'b1;
        bus.data_addr       = a;
        bus.data_write_data = d;
        step();
        if (legal(a)) model[int'(a >> 2)] = d;
        idle_bus();
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        bus.data_read_en = 1'b1;
        bus.data_addr    = a;
        exp_q.push_back(mread(a));
        @(negedge clk);
        chk(tag, bus.data_read_data, exp_q.pop_front());
        step();
        idle_bus();
    endtask

    // Counts cycles from now until inst_success, with optional data-read
    // contention per cycle, then compares latency and the queued word.
    task automatic wait_hit(input string tag, input logic [7:0] busy,
                            input int exp_lat);
        int lat;
        lat = -1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            bus.data_read_en = (c < 8) ? busy[c] : 1'b0;
            bus.data_addr    = 32'h0;
            @(negedge clk);
            if (bus.inst_success) lat = c;
            step();
        end
        idle_bus();
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, bus.inst_data, exp_q.pop_front());
    endtask

    task automatic fetch(input string tag, input logic [31:0] a,
                         input logic [7:0] busy, input int exp_lat);
        bus.inst_addr = a;
        exp_q.push_back(mread(a));
        wait_hit(tag, busy, exp_lat);
    endtask

    always @(negedge clk) begin
        if (bus.inst_data == 32'h1111_1111) saw_mem1 = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        bus.inst_addr = 32'h0;
        idle_bus();
        step();
        step();
        @(negedge clk);
        chk("rst_success", bus.inst_success, 1'b0);
        chk("rst_data", bus.inst_data, 32'h0);
        chk("rst_rerr", bus.range_error, 1'b0);
        step();
        reset = 1'b0;

        wr(32'h00, 32'h0050_0093);
        wr(32'h04, 32'h1111_1111);
        wr(32'h08, 32'h2222_2222);
        wr(32'h10, 32'h4444_4444);
        wr(32'h20, 32'hAAAA_0020);
        wr(32'h40, 32'h0BAD_F00D);

        // Store during reset must be dropped; array survives reset.
        reset               = 1'b1;
        bus.data_write_en   = 1'b1;
        bus.data_addr       = 32'h40;
        bus.data_write_data = 32'hBAD0_BAD0;
        step();
        idle_bus();
        @(negedge clk);
        chk("rst2_success", bus.inst_success, 1'b0);
        chk("rst2_data", bus.inst_data, 32'h0);
        step();
        reset = 1'b0;

        // 1: first fetch after reset
        fetch("t1", 32'h0, 8'h00, LAT + 1);

        // 2: read and write same word in one cycle
        bus.data_write_en   = 1'b1;
        bus.data_read_en    = 1'b1;
        bus.data_addr       = 32'h40;
        bus.data_write_data = 32'hDEAD_BEEF;
        exp_q.push_back(mread(32'h40));
        @(negedge clk);
        chk("t2_old", bus.data_read_data, exp_q.pop_front());
        chk("t2_hit_hold", bus.inst_success, 1'b1);
        step();
        model[16] = 32'hDEAD_BEEF;
        idle_bus();
        rd("t2_new", 32'h40);
        bus.data_addr = 32'h40;
        @(negedge clk);
        chk("t2_rd_idle", bus.data_read_data, 32'h0);
        step();

        // 3: two contention cycles in WAIT
        fetch("t3", 32'h8, 8'b0000_0110, LAT + 3);

        // 4: address switch in the first WAIT cycle
        bus.inst_addr = 32'h4;
        step();
        fetch("t4", 32'h10, 8'h00, 3);
        chk("t4_no_mem1", 32'(saw_mem1), 32'h0);

        // 5: store to the held fetch word
        fetch("t5", 32'h20, 8'h00, LAT + 1);
        bus.data_write_en   = 1'b1;
        bus.data_addr       = 32'h20;
        bus.data_write_data = 32'h1234_5678;
        @(negedge clk);
        chk("t5_pre", bus.inst_success, 1'b1);
        step();
        model[8] = 32'h1234_5678;
        idle_bus();
        exp_q.push_back(mread(32'h20));
        @(negedge clk);
        chk("t5_drop", bus.inst_success, 1'b0);
        step();
        @(negedge clk);
        chk("t5_wait", bus.inst_success, 1'b0);
        step();
        @(negedge clk);
        chk("t5_rise", bus.inst_success, 1'b1);
        chk("t5_data", bus.inst_data, exp_q.pop_front());
        step();

        // 6: illegal stores
        bus.data_write_en   = 1'b1;
        bus.data_addr       = 32'h3;
        bus.data_write_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t6_before", bus.range_error, 1'b0);
        step();
        idle_bus();
        @(negedge clk);
        chk("t6_mis", bus.range_error, 1'b1);
        step();
        wr(32'(4 * DEPTH), 32'hEEEE_EEEE);
        rd("t6_word0", 32'h0);
        rd("t6_oob_rd", 32'(4 * DEPTH));
        repeat (5) step();
        @(negedge clk);
        chk("t6_sticky", bus.range_error, 1'b1);
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("t6_rst", bus.range_error, 1'b0);
        step();
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
